// File: rtl/cv32e40s_rf_scrubber.sv
// Background scrubber for the ECC-protected register file: periodically reads x1..x(NUM_WORDS-1),
// hands the word to the SEC-DED decoder, writes back corrected words and raises alert pulses.
module cv32e40s_rf_scrubber #(
  parameter int unsigned NUM_WORDS = 32,
  parameter int unsigned INTERVAL  = 64,
  parameter int unsigned WORD_W    = 38,
  localparam int unsigned AW       = $clog2(NUM_WORDS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable_i,
  output logic [AW-1:0]     raddr_o,
  input  logic [WORD_W-1:0] rdata_i,
  output logic [WORD_W-1:0] dec_data_o,
  input  logic              dec_sec_i,
  input  logic              dec_ded_i,
  input  logic [WORD_W-1:0] dec_corr_i,
  input  logic              core_we_i,
  input  logic [AW-1:0]     core_waddr_i,
  output logic              scrub_we_o,
  output logic [AW-1:0]     scrub_waddr_o,
  output logic [WORD_W-1:0] scrub_wdata_o,
  output logic              minor_alert_o,
  output logic              major_alert_o
);

  localparam int unsigned CW = (INTERVAL > 1) ? $clog2(INTERVAL) : 1;

  typedef enum logic [1:0] {StIdle, StRead, StCheck, StWrite} state_e;

  state_e            state_q, state_d;
  logic [AW-1:0]     addr_q, addr_d, addr_next;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [WORD_W-1:0] cap_q, cap_d;
  logic [WORD_W-1:0] corr_q, corr_d;
  logic              minor_q, minor_d;
  logic              major_q, major_d;
  logic              collision;

  // A core write to the address under scrub makes the captured word stale.
  assign collision = core_we_i && (core_waddr_i == addr_q);
  // x0 is hardwired to zero, so the walk wraps back to x1.
  assign addr_next = (addr_q == AW'(NUM_WORDS - 1)) ? AW'(1) : addr_q + AW'(1);

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    cnt_d      = cnt_q;
    cap_d      = cap_q;
    corr_d     = corr_q;
    minor_d    = 1'b0;
    major_d    = 1'b0;
    scrub_we_o = 1'b0;
    case (state_q)
      StIdle: begin
        if (enable_i) begin
          if (cnt_q == CW'(INTERVAL - 1)) begin
            cnt_d   = '0;
            state_d = StRead;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end else begin
          cnt_d = '0;
        end
      end
      StRead: begin
        cap_d   = rdata_i;
        state_d = StCheck;
      end
      StCheck: begin
        if (collision) begin
          state_d = StRead;
        end else if (dec_ded_i) begin
          major_d = 1'b1;
          addr_d  = addr_next;
          state_d = StIdle;
        end else if (dec_sec_i) begin
          minor_d = 1'b1;
          corr_d  = dec_corr_i;
          state_d = StWrite;
        end else begin
          addr_d  = addr_next;
          state_d = StIdle;
        end
      end
      StWrite: begin
        if (collision) begin
          state_d = StRead;
        end else if (!core_we_i) begin
          // Gated by reset so an abandoned write never reaches the register file.
          scrub_we_o = rst_n;
          addr_d     = addr_next;
          state_d    = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
      addr_q  <= AW'(1);
      cnt_q   <= '0;
      cap_q   <= '0;
      corr_q  <= '0;
      minor_q <= 1'b0;
      major_q <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
      cap_q   <= cap_d;
      corr_q  <= corr_d;
      minor_q <= minor_d;
      major_q <= major_d;
    end
  end

  assign raddr_o       = addr_q;
  assign dec_data_o    = cap_q;
  assign scrub_waddr_o = addr_q;
  assign scrub_wdata_o = corr_q;
  assign minor_alert_o = minor_q;
  assign major_alert_o = major_q;

endmodule

// File: tb/tb_cv32e40s_rf_scrubber.sv
// Directed bench for the register-file scrubber: combinational register-file and decoder models
// driven by address, with per-scenario tasks checking the cycle-exact behaviour.
module tb_cv32e40s_rf_scrubber;
  localparam int unsigned NW = 32;
  localparam int unsigned IV = 4;
  localparam int unsigned W  = 38;
  localparam int unsigned AW = 5;
  localparam logic [W-1:0] CORR = 38'h2A_DEADBEEF;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          enable_i = 1'b0;
  logic [AW-1:0] raddr_o;
  logic [W-1:0]  rdata_i;
  logic [W-1:0]  dec_data_o;
  logic          dec_sec_i;
  logic          dec_ded_i;
  logic [W-1:0]  dec_corr_i;
  logic          core_we_i = 1'b0;
  logic [AW-1:0] core_waddr_i = '0;
  logic          scrub_we_o;
  logic [AW-1:0] scrub_waddr_o;
  logic [W-1:0]  scrub_wdata_o;
  logic          minor_alert_o;
  logic          major_alert_o;

  logic [AW-1:0] sec_addr = '0;
  logic [AW-1:0] ded_addr = '0;
  int checks = 0;
  int errors = 0;

  function automatic logic [W-1:0] word_of(input logic [AW-1:0] a);
    return {6'h15, 27'h0, a};
  endfunction

  // Decoder model flags errors by the address being checked; x0 means no injection.
  assign rdata_i    = word_of(raddr_o);
  assign dec_sec_i  = (sec_addr != '0) && (raddr_o == sec_addr);
  assign dec_ded_i  = (ded_addr != '0) && (raddr_o == ded_addr);
  assign dec_corr_i = CORR;

  cv32e40s_rf_scrubber #(.NUM_WORDS(NW), .INTERVAL(IV), .WORD_W(W)) dut (
    .clk(clk), .rst_n(rst_n), .enable_i(enable_i), .raddr_o(raddr_o), .rdata_i(rdata_i),
    .dec_data_o(dec_data_o), .dec_sec_i(dec_sec_i), .dec_ded_i(dec_ded_i),
    .dec_corr_i(dec_corr_i), .core_we_i(core_we_i), .core_waddr_i(core_waddr_i),
    .scrub_we_o(scrub_we_o), .scrub_waddr_o(scrub_waddr_o), .scrub_wdata_o(scrub_wdata_o),
    .minor_alert_o(minor_alert_o), .major_alert_o(major_alert_o)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    checks++;
    if (scrub_we_o && core_we_i) begin
      errors++;
      $display("FAIL we_exclusive: scrub_we_o=%b core_we_i=%b, required not both 1",
               scrub_we_o, core_we_i);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_addr(input logic [AW-1:0] a, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      step();
      if (raddr_o == a) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; enable_i = 1'b0;
    step(); step();
    checks++; if (raddr_o !== 5'd1) begin errors++; $display("FAIL rst_raddr: got %0d, expected 1", raddr_o); end
    checks++; if (scrub_waddr_o !== 5'd1) begin errors++; $display("FAIL rst_waddr: got %0d, expected 1", scrub_waddr_o); end
    checks++; if (dec_data_o !== '0) begin errors++; $display("FAIL rst_dec_data: got %0h, expected 0", dec_data_o); end
    checks++; if (scrub_wdata_o !== '0) begin errors++; $display("FAIL rst_wdata: got %0h, expected 0", scrub_wdata_o); end
    checks++; if ({scrub_we_o, minor_alert_o, major_alert_o} !== 3'b000) begin errors++; $display("FAIL rst_flags: got %b, expected 000", {scrub_we_o, minor_alert_o, major_alert_o}); end
    rst_n = 1'b1;
    repeat (10) step();
    checks++; if (raddr_o !== 5'd1 || dec_data_o !== '0) begin errors++; $display("FAIL disabled_hold: got raddr %0d data %0h, expected 1 and 0", raddr_o, dec_data_o); end
  endtask

  task automatic test_sweep();
    enable_i = 1'b1;
    for (int a = 1; a < NW; a++) begin
      for (int k = 0; k < 6; k++) begin
        checks++; if (raddr_o !== AW'(a)) begin errors++; $display("FAIL sweep_raddr: got %0d, expected %0d (phase %0d)", raddr_o, a, k); end
        checks++; if ({scrub_we_o, minor_alert_o, major_alert_o} !== 3'b000) begin errors++; $display("FAIL sweep_quiet: got %b, expected 000 at addr %0d", {scrub_we_o, minor_alert_o, major_alert_o}, a); end
        if (k == 5) begin
          checks++; if (dec_data_o !== word_of(AW'(a))) begin errors++; $display("FAIL sweep_capture: got %0h, expected %0h", dec_data_o, word_of(AW'(a))); end
        end
        step();
      end
    end
    checks++; if (raddr_o !== 5'd1) begin errors++; $display("FAIL sweep_wrap: got %0d, expected 1", raddr_o); end
  endtask

  task automatic test_sec_correct();
    bit ok;
    sec_addr = 5'd5;
    wait_addr(5'd5, ok);
    checks++; if (!ok) begin errors++; $display("FAIL sec_reach: raddr %0d, expected 5", raddr_o); end
    repeat (5) step();
    checks++; if (dec_data_o !== word_of(5'd5) || minor_alert_o !== 1'b0) begin errors++; $display("FAIL sec_check: got %0h/%b, expected %0h/0", dec_data_o, minor_alert_o, word_of(5'd5)); end
    step();
    sec_addr = '0;
    checks++; if ({minor_alert_o, scrub_we_o, major_alert_o} !== 3'b110) begin errors++; $display("FAIL sec_pulse: got %b, expected 110", {minor_alert_o, scrub_we_o, major_alert_o}); end
    checks++; if (scrub_waddr_o !== 5'd5 || scrub_wdata_o !== CORR) begin errors++; $display("FAIL sec_write: got %0d/%0h, expected 5/%0h", scrub_waddr_o, scrub_wdata_o, CORR); end
    step();
    checks++; if (raddr_o !== 5'd6 || minor_alert_o !== 1'b0 || scrub_we_o !== 1'b0) begin errors++; $display("FAIL sec_after: got %0d/%b/%b, expected 6/0/0", raddr_o, minor_alert_o, scrub_we_o); end
  endtask

  task automatic test_ded();
    bit ok;
    sec_addr = 5'd7; ded_addr = 5'd7;
    wait_addr(5'd7, ok);
    checks++; if (!ok) begin errors++; $display("FAIL ded_reach: raddr %0d, expected 7", raddr_o); end
    repeat (6) step();
    checks++; if ({major_alert_o, minor_alert_o, scrub_we_o} !== 3'b100 || raddr_o !== 5'd8) begin errors++; $display("FAIL ded_pulse: got %b addr %0d, expected 100 addr 8", {major_alert_o, minor_alert_o, scrub_we_o}, raddr_o); end
    sec_addr = '0; ded_addr = '0;
    step();
    checks++; if (major_alert_o !== 1'b0) begin errors++; $display("FAIL ded_single: got %b, expected 0", major_alert_o); end
  endtask

  task automatic test_stall();
    bit ok;
    sec_addr = 5'd9;
    wait_addr(5'd9, ok);
    checks++; if (!ok) begin errors++; $display("FAIL stall_reach: raddr %0d, expected 9", raddr_o); end
    repeat (5) step();
    core_we_i = 1'b1; core_waddr_i = 5'd3;
    step();
    sec_addr = '0;
    checks++; if (minor_alert_o !== 1'b1 || scrub_we_o !== 1'b0) begin errors++; $display("FAIL stall_w1: got minor %b we %b, expected 1 0", minor_alert_o, scrub_we_o); end
    step();
    checks++; if (scrub_we_o !== 1'b0 || raddr_o !== 5'd9) begin errors++; $display("FAIL stall_w2: got we %b addr %0d, expected 0 9", scrub_we_o, raddr_o); end
    step();
    checks++; if (scrub_we_o !== 1'b0) begin errors++; $display("FAIL stall_w3: got we %b, expected 0", scrub_we_o); end
    core_we_i = 1'b0;
    #1;
    checks++; if (scrub_we_o !== 1'b1 || scrub_waddr_o !== 5'd9 || scrub_wdata_o !== CORR) begin errors++; $display("FAIL stall_release: got %b/%0d/%0h, expected 1/9/%0h", scrub_we_o, scrub_waddr_o, scrub_wdata_o, CORR); end
    step();
    checks++; if (raddr_o !== 5'd10 || scrub_we_o !== 1'b0) begin errors++; $display("FAIL stall_after: got %0d/%b, expected 10/0", raddr_o, scrub_we_o); end
  endtask

  task automatic test_collision();
    bit ok;
    sec_addr = 5'd11;
    wait_addr(5'd11, ok);
    checks++; if (!ok) begin errors++; $display("FAIL coll_reach: raddr %0d, expected 11", raddr_o); end
    repeat (6) step();
    checks++; if (minor_alert_o !== 1'b1 || scrub_we_o !== 1'b1) begin errors++; $display("FAIL coll_w1: got minor %b we %b, expected 1 1", minor_alert_o, scrub_we_o); end
    core_we_i = 1'b1; core_waddr_i = 5'd11; sec_addr = '0;
    #1;
    checks++; if (scrub_we_o !== 1'b0) begin errors++; $display("FAIL coll_nowrite: got we %b, expected 0", scrub_we_o); end
    step();
    core_we_i = 1'b0;
    checks++; if (raddr_o !== 5'd11 || minor_alert_o !== 1'b0) begin errors++; $display("FAIL coll_reread: got %0d/%b, expected 11/0", raddr_o, minor_alert_o); end
    step();
    checks++; if (dec_data_o !== word_of(5'd11)) begin errors++; $display("FAIL coll_capture: got %0h, expected %0h", dec_data_o, word_of(5'd11)); end
    step();
    checks++; if (raddr_o !== 5'd12 || {minor_alert_o, major_alert_o, scrub_we_o} !== 3'b000) begin errors++; $display("FAIL coll_advance: got %0d/%b, expected 12/000", raddr_o, {minor_alert_o, major_alert_o, scrub_we_o}); end
  endtask

  task automatic test_check_collision();
    bit ok;
    ded_addr = 5'd13;
    wait_addr(5'd13, ok);
    checks++; if (!ok) begin errors++; $display("FAIL ccoll_reach: raddr %0d, expected 13", raddr_o); end
    repeat (4) step();
    core_we_i = 1'b1; core_waddr_i = 5'd13;
    step();
    step();
    core_we_i = 1'b0; ded_addr = '0;
    checks++; if (major_alert_o !== 1'b0 || raddr_o !== 5'd13) begin errors++; $display("FAIL ccoll_wins: got major %b addr %0d, expected 0 13", major_alert_o, raddr_o); end
    step();
    checks++; if (dec_data_o !== word_of(5'd13)) begin errors++; $display("FAIL ccoll_capture: got %0h, expected %0h", dec_data_o, word_of(5'd13)); end
    step();
    checks++; if (raddr_o !== 5'd14 || major_alert_o !== 1'b0) begin errors++; $display("FAIL ccoll_advance: got %0d/%b, expected 14/0", raddr_o, major_alert_o); end
  endtask

  task automatic test_reset_in_write();
    bit ok;
    sec_addr = 5'd15;
    wait_addr(5'd15, ok);
    checks++; if (!ok) begin errors++; $display("FAIL rstw_reach: raddr %0d, expected 15", raddr_o); end
    repeat (5) step();
    core_we_i = 1'b1; core_waddr_i = 5'd3;
    step();
    checks++; if (minor_alert_o !== 1'b1 || scrub_we_o !== 1'b0) begin errors++; $display("FAIL rstw_w1: got minor %b we %b, expected 1 0", minor_alert_o, scrub_we_o); end
    rst_n = 1'b0; core_we_i = 1'b0; sec_addr = '0;
    #1;
    checks++; if (scrub_we_o !== 1'b0) begin errors++; $display("FAIL rstw_nowrite: got we %b, expected 0", scrub_we_o); end
    step();
    rst_n = 1'b1;
    checks++; if (raddr_o !== 5'd1 || {minor_alert_o, major_alert_o, scrub_we_o} !== 3'b000) begin errors++; $display("FAIL rstw_state: got %0d/%b, expected 1/000", raddr_o, {minor_alert_o, major_alert_o, scrub_we_o}); end
    checks++; if (dec_data_o !== '0 || scrub_wdata_o !== '0) begin errors++; $display("FAIL rstw_regs: got %0h/%0h, expected 0/0", dec_data_o, scrub_wdata_o); end
    repeat (4) step();
    checks++; if (dec_data_o !== '0) begin errors++; $display("FAIL rstw_early: got %0h, expected 0", dec_data_o); end
    step();
    checks++; if (dec_data_o !== word_of(5'd1)) begin errors++; $display("FAIL rstw_read: got %0h, expected %0h", dec_data_o, word_of(5'd1)); end
    step();
    checks++; if (raddr_o !== 5'd2) begin errors++; $display("FAIL rstw_next: got %0d, expected 2", raddr_o); end
  endtask

  task automatic test_enable_fall();
    repeat (4) step();
    enable_i = 1'b0;
    step();
    step();
    checks++; if (raddr_o !== 5'd3) begin errors++; $display("FAIL en_complete: got %0d, expected 3", raddr_o); end
    repeat (10) step();
    checks++; if (raddr_o !== 5'd3 || dec_data_o !== word_of(5'd2)) begin errors++; $display("FAIL en_parked: got %0d/%0h, expected 3/%0h", raddr_o, dec_data_o, word_of(5'd2)); end
  endtask

  initial begin
    test_reset();
    test_sweep();
    test_sec_correct();
    test_ded();
    test_stall();
    test_collision();
    test_check_collision();
    test_reset_in_write();
    test_enable_fall();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
